// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer between execute stage and data bus
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_exc,
    output logic [3:0]  rsp_cause,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q, cnt, wdata_d, load_val;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wr_q, uns_q;
    logic        accept, illegal, misal, hs, rdone, fault;
    logic [7:0]  lb;
    logic [15:0] lh;

    // request decode, lane generation and load-lane extraction
    always_comb begin
        accept   = state == IDLE && req_valid;
        illegal  = req_load == req_store || req_size == 2'd3;
        misal    = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        hs       = state == REQ && mem_ready;
        rdone    = state == WAIT && mem_rvalid;
        fault    = TIMEOUT_CYCLES != 0 && (state == REQ || state == WAIT)
                   && cnt + 32'd1 == TIMEOUT_CYCLES && !hs && !rdone;
        wstrb_d  = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                   req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
        wdata_d  = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                   req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
        lb       = wstrb_q[3] ? mem_rdata[31:24] : wstrb_q[2] ? mem_rdata[23:16] :
                   wstrb_q[1] ? mem_rdata[15:8] : mem_rdata[7:0];
        lh       = wstrb_q[2] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = wstrb_q == 4'hF ? mem_rdata :
                   (wstrb_q == 4'h3 || wstrb_q == 4'hC) ? {{16{lh[15] & ~uns_q}}, lh} :
                   {{24{lb[7] & ~uns_q}}, lb};
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state logic; a completing handshake or read beats a same-cycle timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((illegal || misal) ? RESP : REQ) : IDLE;
            REQ:     state_n = hs ? (wr_q ? RESP : WAIT) : fault ? RESP : REQ;
            WAIT:    state_n = (rdone || fault) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        req_ready = state == IDLE;
        mem_valid = state == REQ;
        rsp_valid = state == RESP;
        busy      = state != IDLE;
    end

    // latched request fields, timeout counter and held response
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_exc   <= 1'b0;
            rsp_cause <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                wr_q    <= req_store;
                uns_q   <= req_unsigned;
                cnt     <= '0;
                if (illegal || misal) begin
                    rsp_exc   <= 1'b1;
                    rsp_cause <= illegal ? 4'd2 : req_store ? 4'd6 : 4'd4;
                    rsp_data  <= req_addr;
                end
            end
            if (state == REQ || state == WAIT) cnt <= cnt + 32'd1;
            if ((hs && wr_q) || rdone) begin
                rsp_exc   <= 1'b0;
                rsp_cause <= 4'd0;
                rsp_data  <= rdone ? load_val : 32'd0;
            end else if (fault) begin
                rsp_exc   <= 1'b1;
                rsp_cause <= wr_q ? 4'd7 : 4'd5;
                rsp_data  <= addr_q;
            end
        end
    end

    assign mem_wr    = wr_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl sequencing, lanes, exceptions and timeout
module tb_lsu_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 0, req_ready, req_load = 0, req_store = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        mem_valid, mem_ready = 0, mem_wr, mem_rvalid = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_exc, busy;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_cause;
    int          n_chk = 0, n_pass = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_exc(rsp_exc), .rsp_cause(rsp_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one request for the accept edge, then withdraw it
    task automatic start(input logic ld, input logic st, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = un; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic un, input logic [31:0] rd,
                           input logic [3:0] strb, input logic [31:0] exp);
        start(1, 0, sz, un, a, 32'h0);
        check({tag, "_mvalid"}, mem_valid, 1);
        check({tag, "_wr"}, mem_wr, 0);
        check({tag, "_strb"}, mem_wstrb, strb);
        check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        check({tag, "_rdy_busy"}, req_ready, 0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check({tag, "_mvalid_drop"}, mem_valid, 0);
        check({tag, "_no_early_rsp"}, rsp_valid, 0);
        mem_rvalid = 1; mem_rdata = rd;
        tick();
        mem_rvalid = 0;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_data"}, rsp_data, exp);
        check({tag, "_rsp_exc"}, rsp_exc, 0);
        tick();
        check({tag, "_rsp_1cyc"}, rsp_valid, 0);
        check({tag, "_rsp_hold"}, rsp_data, exp);
    endtask

    initial begin
        int mv;
        tick(); tick();
        check("rst_mvalid", mem_valid, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_strb", mem_wstrb, 0);
        check("rst_rdata", rsp_data, 0);
        check("rst_cause", rsp_cause, 0);
        rst = 0;
        #1;
        check("rst_ready", req_ready, 1);

        do_load("lb", 32'h1003, 2'd0, 0, 32'h80AA55CC, 4'h8, 32'hFFFFFF80);
        do_load("lhu", 32'h2002, 2'd1, 1, 32'hF00D1234, 4'hC, 32'h0000F00D);
        do_load("lh", 32'h9000, 2'd1, 0, 32'h12348001, 4'h3, 32'hFFFF8001);
        do_load("lbu", 32'h9001, 2'd0, 1, 32'h0000A500, 4'h2, 32'h000000A5);
        do_load("lw", 32'h9004, 2'd2, 0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);

        start(0, 1, 2'd1, 0, 32'h3002, 32'h0000BEEF);
        for (int i = 0; i < 3; i++) begin
            check("sh_mvalid", mem_valid, 1);
            check("sh_strb", mem_wstrb, 4'hC);
            check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
            tick();
        end
        mem_ready = 1;
        check("sh_mvalid4", mem_valid, 1);
        check("sh_wr", mem_wr, 1);
        check("sh_addr", mem_addr, 32'h3000);
        tick();
        mem_ready = 0;
        check("sh_rsp_valid", rsp_valid, 1);
        check("sh_rsp_exc", rsp_exc, 0);
        check("sh_rsp_data", rsp_data, 0);
        check("sh_mvalid_drop", mem_valid, 0);
        tick();
        check("sh_rsp_1cyc", rsp_valid, 0);

        mem_ready = 1;
        start(0, 1, 2'd0, 0, 32'hA001, 32'h0000005A);
        check("sb_mvalid_c1", mem_valid, 1);
        check("sb_strb", mem_wstrb, 4'h2);
        check("sb_wdata", mem_wdata, 32'h5A5A5A5A);
        tick();
        mem_ready = 0;
        check("sb_rsp_c2", rsp_valid, 1);
        tick();

        start(1, 0, 2'd2, 0, 32'h4001, 32'h0);
        check("mis_rsp_c1", rsp_valid, 1);
        check("mis_exc", rsp_exc, 1);
        check("mis_cause", rsp_cause, 4);
        check("mis_data", rsp_data, 32'h4001);
        check("mis_no_mem", mem_valid, 0);
        tick();
        check("mis_no_mem2", mem_valid, 0);

        start(0, 1, 2'd1, 0, 32'h8001, 32'h0);
        check("mis_st_cause", rsp_cause, 6);
        tick();

        mv = 0;
        start(0, 1, 2'd2, 0, 32'h5000, 32'h12345678);
        for (int k = 0; k < 20 && !rsp_valid; k++) begin
            if (mem_valid) mv++;
            tick();
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_exc", rsp_exc, 1);
        check("to_cause", rsp_cause, 7);
        check("to_data", rsp_data, 32'h5000);
        check("to_mvalid_low", mem_valid, 0);
        check("to_req_cycles", mv, 8);
        mem_ready = 1; mem_rvalid = 1;
        tick();
        check("to_late_mvalid", mem_valid, 0);
        check("to_late_rsp", rsp_valid, 0);
        check("to_late_hold", rsp_cause, 7);
        tick();
        check("to_late_idle", busy, 0);
        mem_ready = 0; mem_rvalid = 0;

        start(1, 0, 2'd2, 0, 32'h6000, 32'h0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("rw_busy", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rw_no_rsp", rsp_valid, 0);
        check("rw_ready", req_ready, 1);
        check("rw_mvalid", mem_valid, 0);
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        check("rw_ign_rvalid", rsp_valid, 0);

        start(1, 1, 2'd2, 0, 32'h7000, 32'h0);
        check("ill_rsp", rsp_valid, 1);
        check("ill_exc", rsp_exc, 1);
        check("ill_cause", rsp_cause, 2);
        check("ill_data", rsp_data, 32'h7000);
        tick();
        start(1, 0, 2'd3, 0, 32'h7100, 32'h0);
        check("ill_sz_cause", rsp_cause, 2);
        check("ill_sz_mvalid", mem_valid, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Sequences one data-memory access at a time between the execute stage and the data bus. Accepts load/store requests and generates byte-lane strobes and lane-replicated store data.
- Drives a valid/ready memory request and waits for load data. Extracts and sign/zero-extends the addressed lane, then returns a single-cycle response.
- Detects misaligned, illegal and timed-out accesses and reports them as exceptions with RISC-V cause codes.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before an access fault is reported; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request from pipeline
req_ready  out  1  controller can accept a request (high only in IDLE)
req_load  in  1  request is a load
req_store  in  1  request is a store
req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned  in  1  zero-extend load (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_wr  out  1  1 store, 0 load
mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
mem_wstrb  out  4  byte-lane mask (driven for loads and stores)
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data, full word
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  32  load result; faulting address on exception; 0 for stores
rsp_exc  out  1  response is an exception
rsp_cause  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; mem_valid, mem_wr, mem_wstrb, mem_wdata, mem_addr, rsp_valid, rsp_exc, rsp_cause, rsp_data, busy and the timeout counter all 0.
  - req_ready is 1 from the first cycle with rst=0.
  - Reset mid-access abandons the access: no rsp_valid, mem_valid low on the next cycle.
- States: IDLE, REQ, WAIT, RESP. Only one access is in flight at a time.
- IDLE: req_ready=1. A request is accepted on req_valid=1 and its fields are latched.
  - Illegal: req_load==req_store, or req_size==3. Go to RESP with exc=1, cause=2, rsp_data=req_addr.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with exc=1, cause 4 (load) or 6 (store), rsp_data=req_addr. No memory request is issued.
  - Otherwise go to REQ. Timeout counter is cleared.
- Lane generation:
  - Byte: wstrb=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Half: wstrb=4'b0011<<addr[1:0]; wdata={2{wdata[15:0]}}.
  - Word: wstrb=4'hF; wdata=wdata.
- REQ: mem_valid=1; mem_addr, mem_wr, mem_wstrb and mem_wdata are held stable until the cycle mem_valid&&mem_ready.
  - On handshake, a store goes to RESP (exc=0, rsp_data=0) and a load goes to WAIT.
  - mem_valid is 0 in the cycle after the handshake.
- WAIT: mem_rvalid is sampled only in WAIT, i.e. no earlier than the cycle after the handshake.
  - On mem_rvalid, select the lane from mem_rdata by wstrb: byte lanes 1/2/4/8 map to bits [7:0]/[15:8]/[23:16]/[31:24]; half lanes 3/C map to [15:0]/[31:16]; word lane F is the full word.
  - Sign-extend from bit 7/15 unless req_unsigned, then register into rsp_data and go to RESP.
  - mem_rvalid outside WAIT is ignored.
- Timeout: the counter increments every cycle in REQ or WAIT. If it reaches TIMEOUT_CYCLES (when nonzero) before completion, go to RESP with exc=1, cause 5 (load) or 7 (store), rsp_data=address.
  - mem_valid drops on the next cycle.
  - Completion in the same cycle as the timeout wins over the timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data, rsp_exc and rsp_cause hold until the next response.
- Minimum latency (cycle 0 = accept):
  - Store with mem_ready=1: mem_valid in cycle 1, rsp_valid in cycle 2.
  - Load with mem_ready=1 and rvalid in cycle 2: rsp_valid in cycle 3.
  - Exception without memory access: rsp_valid in cycle 1.

Test Plan:
- Load byte signed: addr=0x1003, size=0, mem_rdata=0x80AA55CC. Required: mem_wstrb=4'h8, mem_addr=0x1000, rsp_data=0xFFFFFF80, exc=0.
- Load half unsigned: addr=0x2002, size=1, mem_rdata=0xF00D1234. Required: wstrb=4'hC, rsp_data=0x0000F00D.
- Store half: addr=0x3002, wdata=0x0000BEEF, mem_ready low for 3 cycles. Required: mem_valid held 4 cycles with stable wstrb=4'hC and wdata=0xBEEFBEEF, then rsp_valid 1 cycle after the handshake.
- Misaligned word load: addr=0x4001. Required: no mem_valid; rsp_valid in cycle 1 with exc=1, cause=4, rsp_data=0x4001.
- Timeout: TIMEOUT_CYCLES=8, store with mem_ready held 0. Required: rsp exc=1, cause=7; mem_valid low afterwards; a late mem_ready/mem_rvalid has no effect.
- Reset in WAIT, plus illegal request: rst asserted in WAIT gives no rsp_valid and req_ready=1 after release. A request with req_load=req_store=1 gives exc=1, cause=2.
